button_load_conditioner: RTL and testbench

BUTTON_LOAD_CONDITIONER -- requirements
Module: button_load_conditioner

---
 rtl/button_load_conditioner.sv | 124 ++++++++++++
 tb/tb_button_load_conditioner.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/button_load_conditioner.sv
// Debounced load push-button: synchronizes the button and switches, accepts a press after
// DEBOUNCE_CYCLES stable samples and emits one enable_out strobe with the captured switch word.
// Optional build macro LOAD_COUNT_EN adds an 8-bit load_count output that counts accepted loads.
//
// state        | meaning
// IDLE         | button released and debounced, waiting for a press
// PRESS_WAIT   | button seen high, counting stable high samples
// PRESSED      | press accepted, strobe cycle
// RELEASE_WAIT | waiting for DEBOUNCE_CYCLES stable low samples
module button_load_conditioner #(
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic       clk,
    input  logic       rst_ext_n,
    input  logic       btn_load_in,
    input  logic [3:0] sw_in,
    output logic       enable_out,
    output logic [3:0] d_out,
    output logic       busy
`ifdef LOAD_COUNT_EN
    ,
    output logic [7:0] load_count
`endif
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    typedef enum logic [1:0] {
        IDLE,
        PRESS_WAIT,
        PRESSED,
        RELEASE_WAIT
    } state_t;

    state_t        state;
    logic [CW-1:0] cnt;
    logic [1:0]    btn_ff;
    logic [3:0]    sw_ff1;
    logic [3:0]    sw_sync;
    logic          btn_sync;

    assign btn_sync = btn_ff[1];

    always_ff @(posedge clk or negedge rst_ext_n) begin
        if (!rst_ext_n) begin
            btn_ff  <= 2'b00;
            sw_ff1  <= 4'b0000;
            sw_sync <= 4'b0000;
        end else begin
            btn_ff  <= {btn_ff[0], btn_load_in};
            sw_ff1  <= sw_in;
            sw_sync <= sw_ff1;
        end
    end

    // busy is assigned alongside each transition so it tracks the registered state exactly
    always_ff @(posedge clk or negedge rst_ext_n) begin
        if (!rst_ext_n) begin
            state      <= IDLE;
            cnt        <= '0;
            enable_out <= 1'b0;
            d_out      <= 4'b0000;
            busy       <= 1'b0;
`ifdef LOAD_COUNT_EN
            load_count <= 8'd0;
`endif
        end else begin
            enable_out <= 1'b0;
            case (state)
                IDLE: begin
                    if (btn_sync) begin
                        state <= PRESS_WAIT;
                        cnt   <= CNT_ONE;
                        busy  <= 1'b1;
                    end else begin
                        cnt  <= '0;
                        busy <= 1'b0;
                    end
                end
                PRESS_WAIT: begin
                    if (!btn_sync) begin
                        state <= IDLE;
                        cnt   <= '0;
                        busy  <= 1'b0;
                    end else if (cnt == CNT_LAST) begin
                        state      <= PRESSED;
                        enable_out <= 1'b1;
                        d_out      <= sw_sync;
                        busy       <= 1'b1;
`ifdef LOAD_COUNT_EN
                        load_count <= load_count + 8'd1;
`endif
                    end else begin
                        cnt <= cnt + CNT_ONE;
                    end
                end
                PRESSED: begin
                    state <= RELEASE_WAIT;
                    cnt   <= '0;
                    busy  <= 1'b1;
                end
                RELEASE_WAIT: begin
                    if (btn_sync) begin
                        cnt <= '0;
                    end else if (cnt == CNT_LAST) begin
                        state <= IDLE;
                        cnt   <= '0;
                        busy  <= 1'b0;
                    end else begin
                        cnt <= cnt + CNT_ONE;
                    end
                end
                default: begin
                    state <= IDLE;
                    cnt   <= '0;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_button_load_conditioner.sv
// Bench for button_load_conditioner with DEBOUNCE_CYCLES=4: vector table plus corner sequences,
// expected load words queued at stimulus time and popped when the strobe appears.
module tb_button_load_conditioner;

    localparam int DC = 4;

    logic       clk;
    logic       rst_ext_n;
    logic       btn_load_in;
    logic [3:0] sw_in;
    logic       enable_out;
    logic [3:0] d_out;
    logic       busy;
`ifdef LOAD_COUNT_EN
    logic [7:0] load_count;
`endif

    button_load_conditioner #(.DEBOUNCE_CYCLES(DC)) dut (
        .clk         (clk),
        .rst_ext_n   (rst_ext_n),
        .btn_load_in (btn_load_in),
        .sw_in       (sw_in),
        .enable_out  (enable_out),
        .d_out       (d_out),
        .busy        (busy)
`ifdef LOAD_COUNT_EN
        ,
        .load_count  (load_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    logic [3:0] exp_q[$];
    logic [3:0] d_model = 4'b0000;
    logic       prev_en = 1'b0;
    int         lc_model = 0;

    typedef struct {
        logic [3:0] sw;
        int         hold;
        bit         strobe;
    } vec_t;

    vec_t vecs[8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Scoreboard side: every strobe must match the oldest queued word; d_out must hold otherwise.
    always @(negedge clk) begin
        if (rst_ext_n) begin
            if (enable_out) begin
                check("double_strobe", 32'(prev_en), 32'(1'b0));
                if (exp_q.size() == 0) begin
                    check("unexpected_strobe", 32'(enable_out), 32'(1'b0));
                end else begin
                    d_model = exp_q.pop_front();
                    check("strobe_d_out", 32'(d_out), 32'(d_model));
                end
                lc_model = (lc_model + 1) % 256;
            end else begin
                check("d_out_hold", 32'(d_out), 32'(d_model));
            end
            prev_en = enable_out;
        end else begin
            prev_en = 1'b0;
        end
    end

    task automatic do_reset_clear();
        d_model  = 4'b0000;
        lc_model = 0;
        exp_q.delete();
    endtask

    task automatic press(input logic [3:0] sw, input int hold, input bit strobe);
        sw_in = sw;
        if (strobe) exp_q.push_back(sw);
        btn_load_in = 1'b1;
        tick(hold);
        btn_load_in = 1'b0;
        tick(12);
        check("missing_strobe", 32'(exp_q.size()), 32'd0);
        check("idle_busy", 32'(busy), 32'd0);
        check("idle_d_out", 32'(d_out), 32'(d_model));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{4'b1010, 20, 1'b1};
        vecs[1] = '{4'b0101,  4, 1'b1};
        vecs[2] = '{4'b1111,  3, 1'b0};
        vecs[3] = '{4'b0011,  2, 1'b0};
        vecs[4] = '{4'b1100,  1, 1'b0};
        vecs[5] = '{4'b0001, 50, 1'b1};
        vecs[6] = '{4'b1000,  5, 1'b1};
        vecs[7] = '{4'b0000,  8, 1'b1};

        rst_ext_n   = 1'b0;
        btn_load_in = 1'b0;
        sw_in       = 4'b0000;
        tick(3);
        check("rst_enable", 32'(enable_out), 32'd0);
        check("rst_d_out", 32'(d_out), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        rst_ext_n = 1'b1;
        tick(2);

        // Clean press: strobe exactly on edge 6, busy from edge 3
        sw_in = 4'b1010;
        exp_q.push_back(4'b1010);
        btn_load_in = 1'b1;
        for (int e = 1; e <= 20; e++) begin
            tick();
            if (e <= 8) begin
                check($sformatf("clean_en_e%0d", e), 32'(enable_out), 32'(e == 6));
                check($sformatf("clean_busy_e%0d", e), 32'(busy), 32'(e >= 3));
            end
        end
        check("clean_d_out", 32'(d_out), 32'h0000000a);
        btn_load_in = 1'b0;
        tick(12);
        check("clean_drained", 32'(exp_q.size()), 32'd0);

        for (int v = 0; v < 8; v++)
            press(vecs[v].sw, vecs[v].hold, vecs[v].strobe);

        // Press bounce: 1,1,0 then held; strobe 6 edges after the final rise
        sw_in = 4'b0110;
        exp_q.push_back(4'b0110);
        btn_load_in = 1'b1;
        tick(2);
        btn_load_in = 1'b0;
        tick();
        btn_load_in = 1'b1;
        for (int r = 1; r <= 8; r++) begin
            tick();
            check($sformatf("bounce_en_r%0d", r), 32'(enable_out), 32'(r == 6));
        end
        tick(42);
        // Release with 1-cycle high glitches
        btn_load_in = 1'b0;
        tick(2);
        btn_load_in = 1'b1;
        tick();
        btn_load_in = 1'b0;
        tick(2);
        btn_load_in = 1'b1;
        tick();
        btn_load_in = 1'b0;
        for (int k = 1; k <= 6; k++) begin
            tick();
            check($sformatf("release_busy_k%0d", k), 32'(busy), 32'(k < 6));
        end
        tick(5);
        check("bounce_drained", 32'(exp_q.size()), 32'd0);

        // Data freeze
        press(4'b0101, 6, 1'b1);
        sw_in = 4'b1111;
        tick(10);
        check("freeze_d_out", 32'(d_out), 32'h5);

        // Reset mid PRESS_WAIT
        sw_in = 4'b1001;
        btn_load_in = 1'b1;
        tick(4);
        check("pre_rst_busy", 32'(busy), 32'd1);
        #2 rst_ext_n = 1'b0;
        do_reset_clear();
        #1;
        check("mid_rst_enable", 32'(enable_out), 32'd0);
        check("mid_rst_d_out", 32'(d_out), 32'd0);
        check("mid_rst_busy", 32'(busy), 32'd0);
        btn_load_in = 1'b0;
        tick(2);
        rst_ext_n = 1'b1;
        tick(15);
        check("post_rst_no_strobe_d", 32'(d_out), 32'd0);
        check("post_rst_busy", 32'(busy), 32'd0);

        // Reset landing in PRESSED aborts the strobe
        sw_in = 4'b0111;
        btn_load_in = 1'b1;
        tick(6);
        check("pressed_reached", 32'(enable_out), 32'd1);
        rst_ext_n = 1'b0;
        do_reset_clear();
        #1;
        check("pressed_rst_enable", 32'(enable_out), 32'd0);
        check("pressed_rst_d_out", 32'(d_out), 32'd0);
        tick(3);

        // Button held through reset release counts as a fresh press
        exp_q.push_back(4'b0111);
        rst_ext_n = 1'b1;
        for (int e = 1; e <= 8; e++) begin
            tick();
            check($sformatf("held_en_e%0d", e), 32'(enable_out), 32'(e == 6));
        end
        btn_load_in = 1'b0;
        tick(12);
        check("held_drained", 32'(exp_q.size()), 32'd0);
        check("held_d_out", 32'(d_out), 32'h7);

`ifdef LOAD_COUNT_EN
        rst_ext_n = 1'b0;
        do_reset_clear();
        tick(2);
        check("lc_rst", 32'(load_count), 32'd0);
        rst_ext_n = 1'b1;
        tick(2);
        for (int p = 0; p < 3; p++) press(4'(p), 5, 1'b1);
        check("lc_three", 32'(load_count), 32'd3);
        check("lc_model_three", 32'(load_count), 32'(lc_model));
        for (int p = 3; p < 256; p++) press(4'(p), 4, 1'b1);
        check("lc_wrap", 32'(load_count), 32'd0);
`endif

        check("final_queue", 32'(exp_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
